led_multi_ctrl: RTL
===================

Name: led_multi_ctrl

Overview:
- Parametrised multi-channel LED controller. Generalises the single blink divider plus single button-driven LED.
- Each of N_CH channels drives one active-high LED in one of four runtime-selectable modes: OFF, ON, BLINK or BTN. BTN follows a debounced active-low button.
- Per-channel blink half-period and mode are loaded through a simple single-cycle config write port.
- Sits between board pins (buttons/LEDs) and the top-level control logic.

Parameters:
- N_CH, 4, number of channels (1..16).
- CNT_W, 28, width of each blink counter and of cfg_half. Must satisfy RST_HALF < 2^CNT_W.
- RST_HALF, 13_500_000, reset half-period in clk cycles (1 Hz blink at 27 MHz).
- RST_MODE, 2, reset mode of every channel (0 OFF, 1 ON, 2 BLINK, 3 BTN).
- DEB_CYCLES, 270_000, consecutive stable synchronised samples required to accept a button change (10 ms at 27 MHz). Must be at least 1.
- DEB_W, 20, debounce counter width. Must satisfy DEB_CYCLES < 2^DEB_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- btn_n  in  N_CH  raw button pins, asynchronous, active-low (0 = pressed).
- cfg_we  in  1  config write strobe, one cycle.
- cfg_ch  in  4  target channel index.
- cfg_mode  in  2  mode to write.
- cfg_half  in  CNT_W  blink half-period to write, in clk cycles.
- led  out  N_CH  LED drive, active-high, registered.
- btn_state  out  N_CH  debounced button level, 1 = pressed, registered.
- btn_press  out  N_CH  one-cycle pulse on each debounced press edge.

Behaviour:
- Reset (rst=0, async):
  - Every channel: mode=RST_MODE, half=RST_HALF, counter=0, blink phase=0.
  - Debounce: counter=0, stable level=released.
  - Sync flops load 1.
  - Outputs: led=0, btn_state=0, btn_press=0.
- Reset asserted mid-operation aborts everything immediately. There is no partial state.
- Button path, per channel:
  - Two-flop synchroniser on btn_n, then inversion to get a "pressed" level.
  - While the synchronised level equals the stable level, the debounce counter is held at 0.
  - While it differs, the counter increments each cycle.
  - When the counter reaches DEB_CYCLES-1 while still differing, the stable level takes the synchronised value and the counter clears.
  - Any sample equal to the stable level before that point clears the counter (bounce rejection).
  - btn_state is the stable level.
  - btn_press is 1 for exactly the cycle after stable goes 0->1. Releases produce no pulse.
  - Latency from a clean pin edge to btn_state: 2 sync + DEB_CYCLES cycles.
- Blink counter, per channel; runs only in BLINK mode and is held at 0 otherwise:
  - If half==0: counter held at 0, phase held at 0.
  - Else the counter counts 0..half-1. On the cycle counter==half-1 the counter wraps to 0 and phase toggles.
  - Period is 2*half cycles with 50% duty. Comparison is at full CNT_W width, so no truncation occurs.
- LED output register, per channel:
  - OFF gives 0; ON gives 1; BLINK gives the phase; BTN gives btn_state.
  - led updates one cycle after the source changes.
- Config write:
  - On cfg_we=1 with cfg_ch<N_CH, the channel's mode and half load from cfg_mode and cfg_half.
  - The same write clears that channel's counter and phase.
  - cfg_ch>=N_CH is ignored with no side effects. Other channels are never disturbed.
- Simultaneous events:
  - A config write on the same cycle as a terminal count wins: counter=0, phase=0, no toggle.
  - A write of identical values still restarts the phase.
- Channels are fully independent. Button debouncing runs in all modes, including OFF.

Test Plan:
- Params N_CH=2, RST_HALF=5, DEB_CYCLES=4: release rst, no other stimulus -> led[0] and led[1] are 0 for 5 edges, go 1 after the 5th edge, go 0 after the 10th, and repeat with period 10.
- cfg write ch1 mode=3, then btn_n[1] held 0 cleanly -> btn_state[1] goes 1 six cycles after the pin edge, btn_press[1] is a single 1-cycle pulse, led[1]=1 one cycle later. Release -> led[1] returns to 0 and no pulse occurs.
- btn_n[0] toggled 0/1 every 2 cycles for 20 cycles, then held 0 -> no btn_state change or pulse during bouncing; btn_state[0]=1 six cycles after the final edge.
- cfg write ch0 mode=2 half=3 on the exact cycle counter==4 -> no toggle that cycle; next toggle 3 cycles later; period is 6. Channel 1 timing is unchanged.
- cfg writes: ch0 half=0 mode=2 -> led[0] stays 0. cfg_ch=5 -> no channel changes. mode=1 -> led[0]=1 next cycle.
- Assert rst for 1 cycle mid-blink with btn_state=1 -> all outputs 0 immediately; after release, channels resume RST_MODE/RST_HALF from phase 0.

Source files
------------

// File: rtl/led_multi_ctrl.sv
// Multi-channel LED controller: per-channel OFF/ON/BLINK/BTN modes, blink dividers,
// debounced active-low buttons and a single-cycle config write port.
module led_multi_ctrl #(
   parameter int unsigned N_CH       = 4,
   parameter int unsigned CNT_W      = 28,
   parameter int unsigned RST_HALF   = 13_500_000,
   parameter int unsigned RST_MODE   = 2,
   parameter int unsigned DEB_CYCLES = 270_000,
   parameter int unsigned DEB_W      = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_CH-1:0]  btn_n,
   input  logic             cfg_we,
   input  logic [3:0]       cfg_ch,
   input  logic [1:0]       cfg_mode,
   input  logic [CNT_W-1:0] cfg_half,
   output logic [N_CH-1:0]  led,
   output logic [N_CH-1:0]  btn_state,
   output logic [N_CH-1:0]  btn_press
);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_BTN   = 2'd3
   } mode_t;

   localparam mode_t            RST_M    = mode_t'(2'(RST_MODE));
   localparam logic [CNT_W-1:0] RST_H    = CNT_W'(RST_HALF);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

   genvar g;
   for (g = 0; g < N_CH; g++) begin : g_ch
      mode_t            mode_q;
      logic [CNT_W-1:0] half_q;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             phase_q;
      logic             phase_d;
      logic             led_q;
      logic             led_d;
      logic             sync1_q;
      logic             sync2_q;
      logic             stable_q;
      logic             press_q;
      logic [DEB_W-1:0] deb_q;
      logic             wr;
      logic             pressed;

      // Indices >= N_CH never match any generated channel, so they are ignored.
      assign wr      = cfg_we && (cfg_ch == 4'(g));
      assign pressed = ~sync2_q;

      // A config write takes priority over a coincident terminal count.
      always_comb begin
         cnt_d   = cnt_q;
         phase_d = phase_q;
         if (wr) begin
            cnt_d   = '0;
            phase_d = 1'b0;
         end else if (mode_q != MODE_BLINK || half_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
         end else if (cnt_q == half_q - CNT_ONE) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end

      // Blink drives the LED from the phase being registered this edge.
      always_comb begin
         led_d = 1'b0;
         unique case (mode_q)
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_BLINK: led_d = phase_d;
            MODE_BTN:   led_d = stable_q;
            default:    led_d = 1'b0;
         endcase
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            mode_q  <= RST_M;
            half_q  <= RST_H;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            led_q   <= 1'b0;
         end else begin
            if (wr) begin
               mode_q <= mode_t'(cfg_mode);
               half_q <= cfg_half;
            end
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            led_q   <= led_d;
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            deb_q    <= '0;
         end else begin
            sync1_q <= btn_n[g];
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (pressed == stable_q) begin
               deb_q <= '0;
            end else if (deb_q == DEB_LAST) begin
               stable_q <= pressed;
               press_q  <= pressed;
               deb_q    <= '0;
            end else begin
               deb_q <= deb_q + DEB_ONE;
            end
         end
      end

      assign led[g]       = led_q;
      assign btn_state[g] = stable_q;
      assign btn_press[g] = press_q;
   end

endmodule
